// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: whack-a-mole sequencer.
// Picks pseudo-random mole slots and times each mole on the game tick.
// Judges debounced presses, keeps a 2-digit BCD score and ends the game
// after a set number of misses. Single clock domain; every output is registered.
module mole_game_ctrl #(
  parameter int         MOLE_TICKS  = 1000,
  parameter int         FLASH_TICKS = 250,
  parameter int         MISS_LIMIT  = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [2:0] btn_pos,
  output logic [2:0] mole_position,
  output logic       guess_correct,
  output logic       guess_wrong,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic       game_over
);

  // The tick counter is shared by the mole timer and the flash timer.
  localparam int CNT_MAX = (MOLE_TICKS > FLASH_TICKS) ? MOLE_TICKS : FLASH_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] MOLE_LAST  = CNT_W'(MOLE_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);
  localparam logic [2:0]       MISS_MAX   = 3'(MISS_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    SHOW,
    HIT,
    MISS,
    GAME_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [2:0]       misses;
  logic [7:0]       lfsr;
  logic [2:0]       lfsr_mod5;
  logic [2:0]       next_pos;

  // Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), stepping every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Next mole slot: LFSR modulo 5, bumped by one slot so it never repeats.
  always_comb begin
    lfsr_mod5 = 3'(lfsr % 8'd5);
    next_pos  = lfsr_mod5;
    if (lfsr_mod5 == mole_position) begin
      next_pos = (lfsr_mod5 == 3'd4) ? 3'd0 : lfsr_mod5 + 3'd1;
    end
  end

  // Game FSM with registered mole, flags, BCD score, miss count and game_over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      misses        <= 3'd0;
      mole_position <= 3'd2;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      digit_1       <= 4'd0;
      digit_2       <= 4'd0;
      game_over     <= 1'b0;
    end else begin
      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            digit_1       <= 4'd0;
            digit_2       <= 4'd0;
            misses        <= 3'd0;
            mole_position <= next_pos;
            tick_cnt      <= '0;
            game_over     <= 1'b0;
            state         <= SHOW;
          end
        end

        SHOW: begin
          if (btn_valid && (btn_pos <= 3'd4)) begin
            tick_cnt <= '0;
            if (btn_pos == mole_position) begin
              state         <= HIT;
              guess_correct <= 1'b1;
              if (!((digit_1 == 4'd9) && (digit_2 == 4'd9))) begin
                if (digit_2 == 4'd9) begin
                  digit_2 <= 4'd0;
                  digit_1 <= digit_1 + 4'd1;
                end else begin
                  digit_2 <= digit_2 + 4'd1;
                end
              end
            end else begin
              state       <= MISS;
              guess_wrong <= 1'b1;
              if (misses < MISS_MAX) begin
                misses <= misses + 3'd1;
              end
            end
          end else if (tick) begin
            if (tick_cnt == MOLE_LAST) begin
              tick_cnt    <= '0;
              state       <= MISS;
              guess_wrong <= 1'b1;
              if (misses < MISS_MAX) begin
                misses <= misses + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        HIT, MISS: begin
          if (tick) begin
            if (tick_cnt == FLASH_LAST) begin
              tick_cnt      <= '0;
              guess_correct <= 1'b0;
              guess_wrong   <= 1'b0;
              if (misses == MISS_MAX) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                mole_position <= next_pos;
                state         <= SHOW;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
